rs_dec: RTL and testbench
=========================

// Module: rs_dec
// PURPOSE
//  Streaming Reed-Solomon RS(N,N-2) decoder over GF(2^8); single-symbol error correction (t=1).
//  Accepts one received symbol per CE strobe and emits the N-2 data symbols of each block.
//  Each output block carries a per-block Valid_out status. Sits between channel deframer and byte sink.
// PARAMETERS
//  N    255  codeword length in symbols (4..255); K=N-2 data symbols (localparam)
//  Field fixed: primitive poly x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02; generator roots alpha^0, alpha^1
// PORTS
//  clk         in   1  clock, all logic on rising edge
//  reset       in   1  asynchronous, active-low reset
//  CE          in   1  input strobe: input_byte sampled on rising clk when CE=1
//  input_byte  in   8  received symbol; first symbol of a block = coefficient r[N-1]
//  Out_byte    out  8  decoded data symbol
//  CEO         out  1  output strobe, 1 for each cycle Out_byte carries a new data symbol
//  Valid_out   out  1  1 while CEO=1 and the current block decoded OK; else 0
// BEHAVIOUR
//  - Reset (reset=0): Out_byte=0, CEO=0, Valid_out=0; symbol counter, syndromes, buffers, FSM cleared.
//    Reset mid-block discards the partial block and any pending output.
//  - Input: symbol counter idx 0..N-1, advances only on CE=1; wraps to 0 after idx N-1.
//    CE=0 holds all input-side state (stalls are legal anywhere in a block).
//  - Each symbol written to half of a 2xN byte ping-pong buffer; halves swap at block end.
//  - Syndromes, Horner form, per CE: S0<=S0^b; S1<=mul(S1,alpha)^b. Both cleared at block start.
//  - Decision (cycle after last symbol, edge T+1 where T samples idx N-1):
//    S0=0,S1=0 -> no error, OK. S0!=0,S1!=0 -> L=(log S1 - log S0) mod 255.
//    If L<N: error at idx p=N-1-L, magnitude S0, OK. Else uncorrectable.
//    Exactly one of S0/S1 zero -> uncorrectable.
//  - GF mult/log/antilog: combinational functions or ROM; no multicycle paths.
//  - Output FSM: IDLE -> DECIDE (1 clk) -> OUT (K clks) -> IDLE.
//    First output registered at edge T+2; CEO=1 on K consecutive cycles.
//    Data idx 0..K-1 emitted in arrival order; parity idx K..N-1 never output.
//  - Out_byte = buf[i] ^ (i==p ? S0 : 0) when corrected; raw buf[i] otherwise.
//  - Valid_out = CEO & OK. When CEO=0: Out_byte holds last value, Valid_out=0.
//  - Back-to-back blocks at CE=1 every cycle: output of block k (K+1 clks) overlaps input of block k+1;
//    no stall, no loss. The next block cannot complete before output ends.
//  - Simultaneous last-symbol input and ongoing output: legal, handled by ping-pong buffer.
// CONFIGURATION
//  RS_CORRECTION_EN defined: correction as above.
//  Not defined: detect-only. Any nonzero syndrome -> block uncorrectable; bytes output raw, Valid_out=0.
//  Locator/log logic omitted. Latency and CEO timing identical in both builds.
// TESTING (N=255)
//  1. Reset pulse, then 255 zero bytes at CE=1
//     -> 253 CEO pulses, first 2 clks after last input; Out_byte=0x00, Valid_out=1.
//  2. Zero block, idx 7 = 0xA5
//     -> all outputs 0x00, Valid_out=1.
//     Without RS_CORRECTION_EN: byte 7 = 0xA5, Valid_out=0 on all 253.
//  3. Zero block, idx 254 (parity, L=0) = 0x33
//     -> 253 zeros, Valid_out=1.
//  4. Zero block, idx 3 = 0x01 and idx 4 = 0x01 (S0=0, S1!=0)
//     -> raw output, bytes 3,4 = 0x01, Valid_out=0.
//  5. Case 2 with CE alternating 1/0
//     -> identical output data; CEO burst begins 2 clks after the CE edge of idx 254.
//  6. Assert reset after 100 symbols of a block
//     -> outputs 0 immediately; the following clean 255-byte zero block decodes as in case 1.

Source files
------------

// File: rtl/rs_dec.sv
// rs_dec: streaming RS(N,N-2) decoder over GF(2^8), t=1 correction; define RS_CORRECTION_EN to enable correction, detect-only otherwise
module rs_dec #(
  parameter int N = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [7:0] input_byte,
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Valid_out
);
  localparam int K = N - 2;
  typedef enum logic [1:0] {IDLE, DECIDE, OUT} state_t;
  state_t state, state_nx;
  logic [7:0] idx, oidx, s0, s1, s1_nx, ss0, ss1, pos, pos_nx;
  logic wsel, rsel, last, ok, corr, ok_nx, corr_nx;
  logic [7:0] mem [2][N];
  function automatic logic [7:0] mul_a(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction
  assign last = CE && idx == 8'(N - 1);
  assign s1_nx = mul_a(s1) ^ input_byte;
  // input side: symbol counter, Horner syndromes, block-end snapshot and ping-pong swap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx  <= '0;
      s0   <= '0;
      s1   <= '0;
      ss0  <= '0;
      ss1  <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else if (CE) begin
      idx <= last ? 8'd0 : idx + 8'd1;
      s0  <= last ? 8'd0 : s0 ^ input_byte;
      s1  <= last ? 8'd0 : s1_nx;
      if (last) begin
        ss0  <= s0 ^ input_byte;
        ss1  <= s1_nx;
        rsel <= wsel;
        wsel <= ~wsel;
      end
    end
  // symbol store; the half being read out is never the half being written
  always_ff @(posedge clk)
    if (CE) mem[wsel][idx] <= input_byte;
`ifdef RS_CORRECTION_EN
  logic [7:0] log_t [256];
  logic [7:0] a;
  logic [8:0] l;
  // discrete-log table, constant after elaboration
  always_comb begin
    for (int j = 0; j < 256; j++) log_t[j] = 8'd0;
    a = 8'd1;
    for (int i = 0; i < 255; i++) begin
      log_t[a] = 8'(i);
      a = mul_a(a);
    end
  end
  // locator: S1/S0 = alpha^L gives error at idx N-1-L with magnitude S0
  always_comb begin
    l = log_t[ss1] >= log_t[ss0] ? {1'b0, log_t[ss1]} - {1'b0, log_t[ss0]}
                                 : {1'b0, log_t[ss1]} + 9'd255 - {1'b0, log_t[ss0]};
    corr_nx = ss0 != 8'd0 && ss1 != 8'd0 && l < 9'(N);
    ok_nx = (ss0 == 8'd0 && ss1 == 8'd0) || corr_nx;
    pos_nx = 8'(N - 1) - l[7:0];
  end
`else
  // detect-only: any nonzero syndrome fails the block
  always_comb begin
    ok_nx = ss0 == 8'd0 && ss1 == 8'd0;
    corr_nx = 1'b0;
    pos_nx = 8'd0;
  end
`endif
  // output FSM next state; a completed block always restarts the decision
  always_comb begin
    state_nx = last ? DECIDE
             : state == DECIDE ? OUT
             : (state == OUT && oidx == 8'(K - 1)) ? IDLE : state;
  end
  // FSM state, output index and per-block decision registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      oidx  <= '0;
      ok    <= 1'b0;
      corr  <= 1'b0;
      pos   <= '0;
    end else begin
      state <= state_nx;
      oidx  <= state == OUT ? oidx + 8'd1 : 8'd0;
      if (state == DECIDE) begin
        ok   <= ok_nx;
        corr <= corr_nx;
        pos  <= pos_nx;
      end
    end
  // registered data output; Out_byte holds between bursts
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Out_byte  <= '0;
      CEO       <= 1'b0;
      Valid_out <= 1'b0;
    end else if (state == OUT) begin
      Out_byte  <= mem[rsel][oidx] ^ (corr && oidx == pos ? ss0 : 8'h00);
      CEO       <= 1'b1;
      Valid_out <= ok;
    end else begin
      CEO       <= 1'b0;
      Valid_out <= 1'b0;
    end
endmodule

// File: tb/tb_rs_dec.sv
// tb_rs_dec: directed self-checking bench for rs_dec (N=255), both RS_CORRECTION_EN builds
module tb_rs_dec;
`ifdef RS_CORRECTION_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, CE = 1'b0;
  logic [7:0] input_byte = 8'h00;
  logic [7:0] Out_byte;
  logic CEO, Valid_out;
  int cyc = 0, first_cyc = -1, nvec = 0, nerr = 0, t0 = 0, t1 = 0;
  logic [7:0] got_b[$];
  logic got_v[$];
  logic [7:0] blk [255];

  rs_dec #(.N(255)) dut (
    .clk(clk), .reset(reset), .CE(CE), .input_byte(input_byte),
    .Out_byte(Out_byte), .CEO(CEO), .Valid_out(Valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (CEO === 1'b1) begin
      if (got_b.size() == 0) first_cyc = cyc;
      got_b.push_back(Out_byte);
      got_v.push_back(Valid_out);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mk(input int ia, input logic [7:0] va, input int ib, input logic [7:0] vb);
    foreach (blk[i]) blk[i] = 8'h00;
    if (ia >= 0) blk[ia] = va;
    if (ib >= 0) blk[ib] = vb;
  endtask

  task automatic clr();
    got_b.delete();
    got_v.delete();
    first_cyc = -1;
  endtask

  task automatic send(input bit alt, output int t_last);
    t_last = 0;
    for (int i = 0; i < 255; i++) begin
      CE = 1'b1;
      input_byte = blk[i];
      @(posedge clk); #1;
      if (i == 254) t_last = cyc;
      if (alt) begin
        CE = 1'b0;
        input_byte = 8'hFF;
        @(posedge clk); #1;
      end
    end
    CE = 1'b0;
    input_byte = 8'h00;
  endtask

  task automatic wait_out(input int n, input string tag);
    int k = 0;
    while (got_b.size() < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, " count"}, got_b.size(), n);
  endtask

  task automatic check_out(input string tag, input int base, input bit ev,
                           input int ia, input logic [7:0] va, input int ib, input logic [7:0] vb);
    int bad = 0, nv = 0;
    logic [7:0] e;
    for (int i = 0; i < 253; i++) begin
      e = i == ia ? va : i == ib ? vb : 8'h00;
      if (base + i >= got_b.size()) bad++;
      else begin
        if (got_b[base + i] !== e) bad++;
        if (got_v[base + i] === 1'b1) nv++;
      end
    end
    chk({tag, " data errs"}, bad, 0);
    chk({tag, " valid cnt"}, nv, ev ? 253 : 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst Out_byte", Out_byte, 8'h00);
    chk("rst CEO", CEO, 1'b0);
    chk("rst Valid_out", Valid_out, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    clr(); mk(-1, 8'h00, -1, 8'h00); send(1'b0, t0);
    wait_out(253, "c1");
    chk("c1 latency", first_cyc - t0, 2);
    check_out("c1", 0, 1'b1, -1, 8'h00, -1, 8'h00);

    clr(); mk(7, 8'hA5, -1, 8'h00); send(1'b0, t0);
    wait_out(253, "c2");
    chk("c2 byte7", got_b[7], CORR ? 8'h00 : 8'hA5);
    check_out("c2", 0, CORR, CORR ? -1 : 7, 8'hA5, -1, 8'h00);

    clr(); mk(254, 8'h33, -1, 8'h00); send(1'b0, t0);
    wait_out(253, "c3");
    check_out("c3", 0, CORR, -1, 8'h00, -1, 8'h00);

    clr(); mk(3, 8'h01, 4, 8'h01); send(1'b0, t0);
    wait_out(253, "c4");
    chk("c4 byte3", got_b[3], 8'h01);
    check_out("c4", 0, 1'b0, 3, 8'h01, 4, 8'h01);

    clr(); mk(7, 8'hA5, -1, 8'h00); send(1'b1, t0);
    wait_out(253, "c5");
    chk("c5 latency", first_cyc - t0, 2);
    check_out("c5", 0, CORR, CORR ? -1 : 7, 8'hA5, -1, 8'h00);

    clr(); mk(7, 8'hA5, -1, 8'h00); send(1'b0, t0);
    mk(200, 8'h5A, -1, 8'h00); send(1'b0, t1);
    wait_out(506, "b2b");
    chk("b2b gap", t1 - t0, 255);
    check_out("b2b blkA", 0, CORR, CORR ? -1 : 7, 8'hA5, -1, 8'h00);
    check_out("b2b blkB", 253, CORR, CORR ? -1 : 200, 8'h5A, -1, 8'h00);

    clr();
    foreach (blk[i]) blk[i] = 8'h11;
    send(1'b0, t0);
    CE = 1'b1;
    input_byte = 8'h22;
    repeat (100) @(posedge clk);
    #1;
    chk("c6 pre CEO", CEO, 1'b1);
    chk("c6 pre byte", Out_byte, 8'h11);
    reset = 1'b0;
    #1;
    chk("c6 rst Out_byte", Out_byte, 8'h00);
    chk("c6 rst CEO", CEO, 1'b0);
    chk("c6 rst Valid_out", Valid_out, 1'b0);
    chk("c6 raw byte0", got_b[0], 8'h11);
    chk("c6 raw valid0", got_v[0], 1'b0);
    CE = 1'b0;
    input_byte = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("c6 no pending CEO", CEO, 1'b0);
    clr(); mk(-1, 8'h00, -1, 8'h00); send(1'b0, t0);
    wait_out(253, "c6");
    chk("c6 latency", first_cyc - t0, 2);
    check_out("c6", 0, 1'b1, -1, 8'h00, -1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
